// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants and types for the 16-bit unpipelined CPU.
//                Holds the fetch FSM state type, instruction field positions,
//                the PC step size and the opcode constants that fetch and
//                control both decode against.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int INSTR_W    = 16;
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 11;
    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int PC_STEP    = 2;

    localparam logic [OPCODE_W-1:0] OPC_HALT = 5'b00000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    function automatic logic [OPCODE_W-1:0] get_opcode(input logic [INSTR_W-1:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_reg
//  Description : Program counter register with load / increment controls and
//                a pending-redirect latch that parks a branch target until the
//                fetch FSM is able to apply it.
//  Ports       : clk, rst_n          clock, async active-low reset
//                i_load, i_load_pc   load PC with a new address (wins over inc)
//                i_inc               advance PC by one instruction
//                i_pend_set/i_pend_pc  capture a redirect target (last wins)
//                i_pend_clr          drop the pending target
//                o_pc, o_pc_inc      current PC and PC + step (wraps)
//                o_pend_valid/o_pend_pc  pending redirect state
//  Revision    : 1.0  initial release
// ============================================================================
module pc_reg
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic [PC_W-1:0] i_load_pc,
    input  logic            i_inc,
    input  logic            i_pend_set,
    input  logic [PC_W-1:0] i_pend_pc,
    input  logic            i_pend_clr,
    output logic [PC_W-1:0] o_pc,
    output logic [PC_W-1:0] o_pc_inc,
    output logic            o_pend_valid,
    output logic [PC_W-1:0] o_pend_pc
);

    logic [PC_W-1:0] r_pc;
    logic            r_pend_valid;
    logic [PC_W-1:0] r_pend_pc;
    logic [PC_W-1:0] w_pc_inc;

    // Natural modulo-2^PC_W wrap: 16'hFFFE + 2 = 16'h0000.
    assign w_pc_inc = r_pc + PC_W'(PC_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= '0;
        end else begin
            if (i_load) begin
                r_pc <= i_load_pc;
            end else if (i_inc) begin
                r_pc <= w_pc_inc;
            end

            // A fresh target always replaces an older one.
            if (i_pend_set) begin
                r_pend_valid <= 1'b1;
                r_pend_pc    <= i_pend_pc;
            end else if (i_pend_clr) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    assign o_pc         = r_pc;
    assign o_pc_inc     = w_pc_inc;
    assign o_pend_valid = r_pend_valid;
    assign o_pend_pc    = r_pend_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Owns the PC, runs a req/ack read
//                against instruction memory, and presents one instruction
//                (word + opcode + PC) to decode. Handles redirects, downstream
//                stall, and stops for good after a HALT is issued.
//  Ports       : clk, rst_n                       clock, async active-low reset
//                imem_req/imem_addr/imem_ack/imem_rdata  memory handshake
//                redirect_valid/redirect_pc       taken branch / jump target
//                stall                            decode not ready
//                instr_valid/instr/opcode/pc/pc_inc  issued instruction
//                halted                           HALT issued, fetch stopped
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                  PC_W     = 16,
    parameter logic [PC_W-1:0]     RESET_PC = 16'h0000,
    parameter logic [OPCODE_W-1:0] HALT_OP  = OPC_HALT
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_pc,
    input  logic                stall,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic [PC_W-1:0]     pc,
    output logic [PC_W-1:0]     pc_inc,
    output logic                halted
);

    fetch_state_t         r_state;
    fetch_state_t         w_state_nxt;
    logic [INSTR_W-1:0]   r_instr;

    logic                 w_capture;
    logic                 w_load;
    logic [PC_W-1:0]      w_load_pc;
    logic                 w_inc;
    logic                 w_pend_set;
    logic                 w_pend_clr;
    logic                 w_pend_valid;
    logic [PC_W-1:0]      w_pend_pc;
    logic [PC_W-1:0]      w_pc;
    logic [PC_W-1:0]      w_pc_inc;
    logic [PC_W-1:0]      w_redir_tgt;
    logic [OPCODE_W-1:0]  w_opcode;

    // Instructions are half-word aligned; bit 0 of the target is dropped.
    assign w_redir_tgt = redirect_pc & ~PC_W'(1);
    assign w_opcode    = get_opcode(r_instr);

    pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_load),
        .i_load_pc    (w_load_pc),
        .i_inc        (w_inc),
        .i_pend_set   (w_pend_set),
        .i_pend_pc    (w_redir_tgt),
        .i_pend_clr   (w_pend_clr),
        .o_pc         (w_pc),
        .o_pc_inc     (w_pc_inc),
        .o_pend_valid (w_pend_valid),
        .o_pend_pc    (w_pend_pc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_load      = 1'b0;
        w_load_pc   = w_redir_tgt;
        w_inc       = 1'b0;
        w_pend_set  = 1'b0;
        w_pend_clr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                // A request in flight is always completed; a redirect seen
                // during it (or with the ack) turns the returned word into a
                // throw-away and re-fetches from the newest target.
                if (imem_ack) begin
                    if (redirect_valid) begin
                        w_load     = 1'b1;
                        w_load_pc  = w_redir_tgt;
                        w_pend_clr = 1'b1;
                    end else if (w_pend_valid) begin
                        w_load     = 1'b1;
                        w_load_pc  = w_pend_pc;
                        w_pend_clr = 1'b1;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_ISSUE;
                    end
                end else if (redirect_valid) begin
                    w_pend_set = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (stall) begin
                    if (redirect_valid) begin
                        w_pend_set = 1'b1;
                    end
                end else if (w_opcode == HALT_OP) begin
                    w_pend_clr  = 1'b1;
                    w_state_nxt = ST_HALT;
                end else begin
                    w_pend_clr  = 1'b1;
                    w_state_nxt = ST_FETCH;
                    if (redirect_valid) begin
                        w_load    = 1'b1;
                        w_load_pc = w_redir_tgt;
                    end else if (w_pend_valid) begin
                        w_load    = 1'b1;
                        w_load_pc = w_pend_pc;
                    end else begin
                        w_inc = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_instr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_instr <= imem_rdata;
            end
        end
    end

    // Decoded straight from the state register so reset drops req at once.
    assign imem_req    = (r_state == ST_FETCH);
    assign imem_addr   = w_pc;
    assign instr_valid = (r_state == ST_ISSUE);
    assign halted      = (r_state == ST_HALT);
    assign instr       = r_instr;
    assign opcode      = w_opcode;
    assign pc          = w_pc;
    assign pc_inc      = w_pc_inc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A memory responder with
//                random wait states, a reference model of the fetch rules that
//                predicts the stream of issued instructions, and a monitor that
//                pops predictions as the DUT issues instructions.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        stall = 1'b0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [4:0]  opcode;
    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic        halted;

    fetch_unit #(
        .PC_W     (16),
        .RESET_PC (16'h0000),
        .HALT_OP  (5'b00000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .opcode         (opcode),
        .pc             (pc),
        .pc_inc         (pc_inc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [0:32767];
    int cfg_wait = 0;
    bit cfg_rand = 1'b0;
    bit cfg_spur = 1'b0;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] word;
    } exp_t;
    exp_t exp_q[$];

    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_ISSUE = 2;
    localparam int P_HALT  = 3;

    int          m_phase = P_IDLE;
    logic [15:0] m_addr  = 16'h0;
    logic [15:0] m_fetch = 16'h0;
    logic [15:0] m_tgt   = 16'h0;
    bit          m_red   = 1'b0;
    bit          m_disc  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req"},    32'(imem_req),    32'd0);
        chk({tag, "_addr"},   32'(imem_addr),   32'h0);
        chk({tag, "_pc"},     32'(pc),          32'h0);
        chk({tag, "_instr"},  32'(instr),       32'h0);
        chk({tag, "_opcode"}, 32'(opcode),      32'h0);
        chk({tag, "_valid"},  32'(instr_valid), 32'd0);
        chk({tag, "_halted"}, 32'(halted),      32'd0);
    endtask

    function automatic exp_t mk(input logic [15:0] a);
        exp_t r;
        r.pc   = a;
        r.word = mem[a[15:1]];
        return r;
    endfunction

    // Instruction memory: random or fixed wait states, optional stray acks
    // while no request is pending.
    initial begin : responder
        int wcnt;
        bit busy;
        wcnt = 0;
        busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            imem_ack   = 1'b0;
            imem_rdata = 16'($urandom);
            if (!rst_n) begin
                busy = 1'b0;
            end else if (imem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    wcnt = cfg_rand ? int'($urandom_range(0, 3)) : cfg_wait;
                end
                if (wcnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem[imem_addr[15:1]];
                    busy       = 1'b0;
                end else begin
                    wcnt--;
                end
            end else begin
                busy = 1'b0;
                if (cfg_spur && ($urandom_range(0, 3) == 0)) begin
                    imem_ack = 1'b1;
                end
            end
        end
    end

    // Reference model: evaluated with the inputs that the coming edge will
    // sample; predicts the phase after that edge and the issued stream.
    always @(negedge clk) begin : model
        logic [15:0] tgt;
        logic [15:0] nxt;
        if (!rst_n) begin
            m_phase = P_IDLE;
            m_addr  = 16'h0;
            m_fetch = 16'h0;
            m_red   = 1'b0;
            m_disc  = 1'b0;
            exp_q.delete();
            exp_q.push_back(mk(16'h0));
        end else begin
            tgt = {redirect_pc[15:1], 1'b0};
            case (m_phase)
                P_IDLE: begin
                    m_phase = P_FETCH;
                    m_fetch = m_addr;
                end
                P_FETCH: begin
                    if (redirect_valid) begin
                        m_addr = tgt;
                        m_disc = 1'b1;
                        void'(exp_q.pop_back());
                        exp_q.push_back(mk(tgt));
                    end
                    if (imem_ack) begin
                        if (m_disc) begin
                            m_disc  = 1'b0;
                            m_fetch = m_addr;
                        end else begin
                            m_phase = P_ISSUE;
                        end
                    end
                end
                P_ISSUE: begin
                    if (redirect_valid) begin
                        m_red = 1'b1;
                        m_tgt = tgt;
                    end
                    if (!stall) begin
                        if (mem[m_addr[15:1]][15:11] == 5'b00000) begin
                            m_phase = P_HALT;
                        end else begin
                            nxt     = m_red ? m_tgt : m_addr + 16'd2;
                            m_red   = 1'b0;
                            m_addr  = nxt;
                            m_fetch = nxt;
                            exp_q.push_back(mk(nxt));
                            m_phase = P_FETCH;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Monitor: per-cycle status against the model, and each newly issued
    // instruction against the head of the prediction queue.
    initial begin : monitor
        bit   prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                chk("sb_valid",  32'(instr_valid), 32'(m_phase == P_ISSUE));
                chk("sb_halted", 32'(halted),      32'(m_phase == P_HALT));
                chk("sb_req",    32'(imem_req),    32'(m_phase == P_FETCH));
                if (imem_req) begin
                    chk("sb_addr", 32'(imem_addr), 32'(m_fetch));
                end
                if (instr_valid && !prev_v) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_unexpected_issue actual pc=%0h required=no instruction", pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_pc",     32'(pc),     32'(e.pc));
                        chk("sb_instr",  32'(instr),  32'(e.word));
                        chk("sb_opcode", 32'(opcode), 32'(e.word[15:11]));
                    end
                end
                prev_v = instr_valid;
            end
        end
    end

    initial begin : main
        logic [15:0] w;
        logic [15:0] hold_i;
        logic [15:0] hold_p;
        int          n;
        bit          seen40;

        for (int i = 0; i < 32768; i++) begin
            do w = 16'($urandom); while (w[15:11] == 5'b00000);
            mem[i] = w;
        end
        mem[0] = 16'hC801;
        mem[1] = 16'h5002;

        repeat (3) step();
        check_reset("rst");

        // Zero-wait fetch of the first two words.
        rst_n = 1'b1;
        step();
        chk("c1_req",  32'(imem_req),  32'd1);
        chk("c1_addr", 32'(imem_addr), 32'h0);
        step();
        chk("c2_valid",  32'(instr_valid), 32'd1);
        chk("c2_opcode", 32'(opcode),      32'h19);
        chk("c2_pc",     32'(pc),          32'h0);
        chk("c2_pc_inc", 32'(pc_inc),      32'h2);
        step();
        chk("c3_req",  32'(imem_req),  32'd1);
        chk("c3_addr", 32'(imem_addr), 32'h2);
        step();
        chk("c4_valid",  32'(instr_valid), 32'd1);
        chk("c4_opcode", 32'(opcode),      32'h0A);
        chk("c4_pc",     32'(pc),          32'h2);

        // Three wait states on the next fetch.
        cfg_wait = 3;
        n = 0;
        step();
        for (int i = 0; i < 12 && !instr_valid; i++) begin
            if (imem_req) begin
                n++;
                chk("wait_addr", 32'(imem_addr), 32'h4);
            end
            step();
        end
        chk("wait_req_cycles", 32'(n),           32'd4);
        chk("wait_valid",      32'(instr_valid), 32'd1);
        chk("wait_pc",         32'(pc),          32'h4);

        // Downstream stall holds the issued instruction.
        stall  = 1'b1;
        hold_i = instr;
        hold_p = pc;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_instr", 32'(instr),       32'(hold_i));
            chk("stall_pc",    32'(pc),          32'(hold_p));
            chk("stall_req",   32'(imem_req),    32'd0);
        end
        cfg_wait = 2;
        stall    = 1'b0;
        step();
        chk("after_stall_req",  32'(imem_req),  32'd1);
        chk("after_stall_addr", 32'(imem_addr), 32'(hold_p + 16'd2));

        // Redirect while a fetch is outstanding.
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0041;
        step();
        redirect_valid = 1'b0;
        seen40 = 1'b0;
        for (int i = 0; i < 20 && !instr_valid; i++) begin
            if (imem_req && imem_addr == 16'h0040) seen40 = 1'b1;
            step();
        end
        chk("redir_refetch", 32'(seen40),      32'd1);
        chk("redir_valid",   32'(instr_valid), 32'd1);
        chk("redir_pc",      32'(pc),          32'h0040);
        chk("redir_instr",   32'(instr),       32'(mem[16'h0020]));

        // PC wrap-around from the top of the address space.
        cfg_wait       = 0;
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFE;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 10 && !instr_valid; i++) step();
        chk("wrap_pc",     32'(pc),     32'hFFFE);
        chk("wrap_pc_inc", 32'(pc_inc), 32'h0);
        step();
        chk("wrap_req",  32'(imem_req),  32'd1);
        chk("wrap_addr", 32'(imem_addr), 32'h0);

        // Randomized traffic; the scoreboard does the checking.
        cfg_rand = 1'b1;
        cfg_spur = 1'b1;
        repeat (3000) begin
            step();
            stall          = ($urandom_range(0, 2) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = 16'($urandom);
        end
        stall          = 1'b0;
        redirect_valid = 1'b0;
        cfg_rand       = 1'b0;
        cfg_spur       = 1'b0;
        cfg_wait       = 0;

        // HALT: jump to a HALT word and check fetch stops for good.
        mem[16'h3000] = 16'h0000;
        for (int i = 0; i < 20 && !instr_valid; i++) step();
        chk("pre_halt_valid", 32'(instr_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h6000;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 20 && !halted; i++) step();
        chk("halt_flag", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            redirect_valid = ($urandom_range(0, 1) == 1);
            redirect_pc    = 16'($urandom);
            step();
            chk("halt_req",   32'(imem_req),    32'd0);
            chk("halt_valid", 32'(instr_valid), 32'd0);
        end
        redirect_valid = 1'b0;

        // Reset asserted in the middle of a fetch clears outputs at once.
        rst_n = 1'b0;
        step();
        step();
        cfg_wait = 5;
        rst_n    = 1'b1;
        step();
        step();
        chk("mid_req", 32'(imem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset("mid_rst");
        step();
        step();
        rst_n    = 1'b1;
        cfg_rand = 1'b1;
        cfg_spur = 1'b1;
        repeat (300) begin
            step();
            stall          = ($urandom_range(0, 2) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc    = 16'($urandom);
        end
        stall          = 1'b0;
        redirect_valid = 1'b0;
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 16-bit unpipelined processor: it owns the program counter, runs a req/ack read handshake against instruction memory, and presents one instruction word plus its 5-bit opcode to the control/decode stage. It sits directly upstream of the control unit, which consumes `instr` and `opcode`. It accepts PC redirects for branches and jumps, stalls from downstream, and stops fetching after a HALT instruction is issued.

## Interface
- `PC_W`, 16, PC and instruction-memory address width.
- `RESET_PC`, 16'h0000, PC loaded on reset.
- `HALT_OP`, 5'b00000, opcode that stops fetching once issued.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  PC_W  byte address of the word being fetched; equals `pc` while `imem_req` is high.
- `imem_ack`  in  1  read complete; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  16  instruction word.
- `redirect_valid`  in  1  branch or jump taken.
- `redirect_pc`  in  PC_W  target address; bit 0 is ignored and forced to 0.
- `stall`  in  1  downstream is not ready to consume the issued instruction.
- `instr_valid`  out  1  `instr`, `opcode` and `pc` describe a live instruction.
- `instr`  out  16  fetched instruction word.
- `opcode`  out  5  `instr[15:11]`.
- `pc`  out  PC_W  address of `instr`, or of the word in flight.
- `pc_inc`  out  PC_W  `pc + 2`, modulo 2^PC_W.
- `halted`  out  1  a HALT instruction has been issued; fetching has stopped.

## Operation
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: entered on reset. Moves to FETCH on the first clock edge after `rst_n` is released.
- FETCH: `imem_req` = 1 and `imem_addr` = `pc`.
  - When `imem_ack` is sampled high, capture `imem_rdata` into `instr` and move to ISSUE.
  - `imem_req` stays high until `imem_ack` arrives. A started request is never abandoned.
- ISSUE: `instr_valid` = 1. `instr`, `opcode` and `pc` hold steady while `stall` = 1.
  - When `stall` = 0, the instruction is consumed at that edge.
  - If `opcode` == HALT_OP, go to HALT.
  - Otherwise, if `redirect_valid` = 1, set `pc` = `{redirect_pc[PC_W-1:1], 1'b0}` and go to FETCH.
  - Otherwise, set `pc` = `pc_inc` and go to FETCH.
- Redirect during FETCH: latch the target into a pending-redirect register.
  - When `imem_ack` arrives, discard the returned data, load `pc` from the pending target, and stay in FETCH. This costs one extra fetch.
  - A later redirect overwrites the pending one; the last one wins.
- Redirect during ISSUE while `stall` = 1: latch it as pending. It is applied when the instruction is consumed.
- Redirect arriving in the same cycle as an ack during FETCH: the data is discarded and the new target is used.
- HALT: `halted` = 1, `imem_req` = 0, `instr_valid` = 0. Redirects are ignored. Only reset exits this state.
- PC wrap-around: 16'hFFFE + 2 = 16'h0000, with no flag.
- `imem_ack` while `imem_req` = 0 is ignored.

## Timing
- Reset values (asynchronous):
  - state = IDLE, `pc` = RESET_PC, `imem_req` = 0, `imem_addr` = RESET_PC.
  - `instr` = 0, `opcode` = 0, `instr_valid` = 0, `halted` = 0, pending redirect cleared.
- Reset asserted mid-transaction: `imem_req` drops immediately (asynchronously). Any later ack for that transaction is ignored.
- Cycle 0 = first edge with `rst_n` high, IDLE→FETCH. `imem_req` is high during cycle 1.
- A zero-wait memory (ack in the first request cycle) gives `instr_valid` one cycle later. Peak throughput is one instruction per 2 cycles.
- Each wait cycle on `imem_ack` adds one cycle of latency.
- `pc_inc` and `opcode` are combinational from registered `pc` and `instr`.

## Structure
- Shared package `cpu_pkg`:
  - state enum `fetch_state_t`
  - `OPC_HALT`, `INSTR_W = 16`, `OPCODE_MSB = 15`, `OPCODE_LSB = 11`
  - `PC_STEP = 2`
  - the control unit uses the same opcode constants.
- Sub-module `pc_reg`: PC register with async reset, load and increment inputs, and a pending-redirect latch. All other logic lives in `fetch_unit`.

## Test plan
- Reset, then a zero-wait memory returning 16'hC801 at address 0 and 16'h5002 at address 2 → `instr_valid` high in cycle 2 with `opcode` = 5'b11001 and `pc` = 0; the next instruction is at `pc` = 2 with `opcode` = 5'b01010.
- Ack delayed 3 cycles → `imem_req` and `imem_addr` held stable for 4 cycles; `instr_valid` asserts the cycle after the ack.
- `stall` high for 5 cycles in ISSUE → `instr`, `pc` and `instr_valid` unchanged; no `imem_req`. After release, the next fetch address is `pc + 2`.
- `redirect_valid` with 16'h0041 during a pending FETCH → returned data discarded; the next request is at 16'h0040; no `instr_valid` for the discarded word.
- `pc` = 16'hFFFE, consumed → the next `imem_addr` is 16'h0000.
- Fetch of 16'h0000 (HALT) consumed → `halted` = 1 and `imem_req` stays 0 for 20 cycles. Asserting `rst_n` low mid-fetch clears every output to its reset value immediately.
